maze_draw_scheduler: RTL
========================

MAZE_DRAW_SCHEDULER -- requirements
Module: maze_draw_scheduler

Interface
REQ-001 SHALL have parameters, one per line: XOFF 80, screen x of tile column 0; PITCH 10, tile pitch in pixels; BOX 9, painted tile edge in pixels; GRID 24, tiles per row and per column.
REQ-002 clk  input  1  single clock; all logic on posedge.
REQ-003 resetn  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 start_maze  input  1  one-cycle pulse requesting a full maze redraw.
REQ-005 maze_done  input  1  from maze position counter; high when the full scan is complete.
REQ-006 maze_x, maze_y  input  9 each  pixel location from maze position counter.
REQ-007 maze_colour  input  3  pixel colour read from maze RAM.
REQ-008 player_req, player_x[4:0], player_y[4:0], player_colour[2:0]  input  level request, tile coordinates, colour.
REQ-009 player_ack  output  1  one-cycle pulse; completes the player request.
REQ-010 maze_enable  output  1  enable to maze position counter.
REQ-011 plot, vga_x[8:0], vga_y[8:0], vga_colour[2:0]  output  shared VGA write port.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 frame_done  output  1  one-cycle pulse at the end of a maze redraw.

Function
REQ-014 SHALL implement FSM IDLE, MAZE, FLUSH, PLAYER.
REQ-015 A start_maze pulse SHALL set maze_pend in any state; maze_pend SHALL clear on entry to MAZE.
REQ-016 In IDLE: if maze_pend, go to MAZE; else if player_req, latch player_x, player_y and player_colour, then go to PLAYER. Maze has priority when both are pending.
REQ-017 In MAZE: maze_enable=1; plot=~maze_done; vga_x, vga_y and vga_colour SHALL pass through combinationally from the maze_* inputs.
REQ-018 In MAZE, maze_done=1 SHALL cause a transition to FLUSH on the next edge.
REQ-019 In FLUSH: maze_enable=0 and plot=0 for exactly one cycle, which lets the counter clear. Then go to IDLE and pulse frame_done in that same cycle.
REQ-020 In PLAYER: scan cx (inner) and cy (outer) over 0..BOX-1, giving BOX*BOX=81 consecutive plot=1 cycles.
REQ-021 Player pixel position: vga_x=XOFF+px*PITCH+cx; vga_y=py*PITCH+cy; computed at 9-bit width with no truncation for px,py<=GRID-1.
REQ-022 vga_colour in PLAYER SHALL be the latched colour.
REQ-023 First player plot SHALL occur in the first cycle in PLAYER.
REQ-024 After the plot at cx=cy=BOX-1, the block SHALL return to IDLE and pulse player_ack in the next cycle.
REQ-025 If latched px>=GRID or py>=GRID, the block SHALL do zero plots, pulse player_ack, and return to IDLE one cycle after entering PLAYER.
REQ-026 player_req asserted during MAZE SHALL be held off (no ack) until the maze redraw completes.
REQ-027 start_maze during PLAYER SHALL be queued in maze_pend; the tile completes first.
REQ-028 plot SHALL be 0 in IDLE and FLUSH. vga_* outputs are don't-care when plot=0.
REQ-029 A requester SHALL keep player_req high until player_ack. Requester-side requirement: player_req is sampled only in IDLE.

Reset
REQ-030 On resetn=0 at posedge, in any state: state=IDLE; maze_pend=0; cx=cy=0; plot=0; maze_enable=0; player_ack=0; frame_done=0; busy=0; vga_x=XOFF; vga_y=0; vga_colour=0.
REQ-031 Reset mid-MAZE or mid-PLAYER SHALL abort the draw. No ack and no frame_done pulse SHALL be issued.

Structure
REQ-032 Package maze_draw_pkg SHALL hold XOFF, PITCH, BOX, GRID and the FSM state encoding.
REQ-033 Sub-module tile_box_scanner SHALL hold the cx/cy counters and the pixel arithmetic: inputs start, px, py; outputs x, y, valid, last.
REQ-034 The scheduler top SHALL hold the FSM, the request latches and the output mux.

Verification
REQ-035 player_req, (0,0), colour 3'b100 -> 81 plots with x 80..88 and y 0..8 in raster order; player_ack one cycle after the last plot.
REQ-036 player_req, (23,23) -> x spans 310..318, y spans 230..238; no overflow.
REQ-037 start_maze and player_req in the same cycle -> MAZE first, counter driven; after maze_done: FLUSH (maze_enable=0, one cycle), frame_done pulse, then the player tile's 81 plots.
REQ-038 player_x=24 -> player_ack with zero plots, busy high for exactly one cycle.
REQ-039 resetn=0 at the 40th PLAYER plot -> plot=0 and busy=0 the next cycle; no player_ack; a new request then draws the full 81 pixels.
REQ-040 start_maze during PLAYER -> tile finishes with 81 plots, ack; MAZE entered the cycle after returning to IDLE.

Source files
------------

// File: rtl/maze_draw_scheduler_pkg.sv
// Shared constants and FSM encoding for the maze/player draw scheduler.
package maze_draw_pkg;

  localparam int XOFF  = 80;
  localparam int PITCH = 10;
  localparam int BOX   = 9;
  localparam int GRID  = 24;

  localparam int XW    = 9;
  localparam int CRDW  = 5;
  localparam int COLW  = 3;
  localparam int CW    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAZE   = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_PLAYER = 2'd3
  } state_t;

endpackage

// File: rtl/maze_draw_scheduler_if.sv
// Bundle of maze counter, player request and shared VGA write port signals.
interface maze_draw_scheduler_if;
  import maze_draw_pkg::*;

  logic            start_maze;
  logic            maze_done;
  logic [XW-1:0]   maze_x;
  logic [XW-1:0]   maze_y;
  logic [COLW-1:0] maze_colour;
  logic            player_req;
  logic [CRDW-1:0] player_x;
  logic [CRDW-1:0] player_y;
  logic [COLW-1:0] player_colour;
  logic            player_ack;
  logic            maze_enable;
  logic            plot;
  logic [XW-1:0]   vga_x;
  logic [XW-1:0]   vga_y;
  logic [COLW-1:0] vga_colour;
  logic            busy;
  logic            frame_done;

  modport master (
    output start_maze, maze_done, maze_x, maze_y, maze_colour,
           player_req, player_x, player_y, player_colour,
    input  player_ack, maze_enable, plot, vga_x, vga_y, vga_colour,
           busy, frame_done
  );

  modport slave (
    input  start_maze, maze_done, maze_x, maze_y, maze_colour,
           player_req, player_x, player_y, player_colour,
    output player_ack, maze_enable, plot, vga_x, vga_y, vga_colour,
           busy, frame_done
  );

endinterface

// File: rtl/maze_draw_scheduler_scanner.sv
// Walks a BOX x BOX tile in raster order and turns tile coordinates into pixels.
module tile_box_scanner #(
  parameter int XOFF  = maze_draw_pkg::XOFF,
  parameter int PITCH = maze_draw_pkg::PITCH,
  parameter int BOX   = maze_draw_pkg::BOX,
  parameter int GRID  = maze_draw_pkg::GRID
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [maze_draw_pkg::CRDW-1:0] px,
  input  logic [maze_draw_pkg::CRDW-1:0] py,
  output logic [maze_draw_pkg::XW-1:0]   x,
  output logic [maze_draw_pkg::XW-1:0]   y,
  output logic                           valid,
  output logic                           last
);
  import maze_draw_pkg::*;

  logic          r_active;
  logic [CW-1:0] r_cx;
  logic [CW-1:0] r_cy;
  logic          w_inRange;
  logic          w_cxEnd;
  logic          w_cyEnd;

  // Off-grid tiles never produce a pixel; the run just ends.
  assign w_inRange = (int'(px) < GRID) && (int'(py) < GRID);
  assign w_cxEnd   = (r_cx == CW'(BOX - 1));
  assign w_cyEnd   = (r_cy == CW'(BOX - 1));
  assign valid     = r_active & w_inRange;
  assign last      = valid & w_cxEnd & w_cyEnd;

  assign x = XW'(XOFF) + XW'(px) * XW'(PITCH) + XW'(r_cx);
  assign y = XW'(py) * XW'(PITCH) + XW'(r_cy);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_active <= 1'b0;
      r_cx     <= '0;
      r_cy     <= '0;
    end else if (start) begin
      r_active <= 1'b1;
      r_cx     <= '0;
      r_cy     <= '0;
    end else if (r_active) begin
      if (!w_inRange || last) begin
        r_active <= 1'b0;
        r_cx     <= '0;
        r_cy     <= '0;
      end else if (w_cxEnd) begin
        r_cx <= '0;
        r_cy <= r_cy + 1'b1;
      end else begin
        r_cx <= r_cx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/maze_draw_scheduler.sv
// Arbitrates the VGA write port between full maze redraws and single player tiles.
module maze_draw_scheduler #(
  parameter int XOFF  = maze_draw_pkg::XOFF,
  parameter int PITCH = maze_draw_pkg::PITCH,
  parameter int BOX   = maze_draw_pkg::BOX,
  parameter int GRID  = maze_draw_pkg::GRID
) (
  input  logic                  clk,
  input  logic                  resetn,
  maze_draw_scheduler_if.slave  bus
);
  import maze_draw_pkg::*;

  state_t          r_state;
  state_t          w_nextState;
  logic            r_mazePend;
  logic            r_playerAck;
  logic            r_frameDone;
  logic [CRDW-1:0] r_px;
  logic [CRDW-1:0] r_py;
  logic [COLW-1:0] r_colour;
  logic            w_mazeWant;
  logic            w_acceptPlayer;
  logic            w_enterMaze;
  logic            w_enterPlayer;
  logic            w_scanValid;
  logic            w_scanLast;
  logic [XW-1:0]   w_scanX;
  logic [XW-1:0]   w_scanY;

  // A start pulse arriving in IDLE wins immediately; the requester still holds
  // player_req during its ack cycle, so that cycle must not re-accept it.
  assign w_mazeWant     = r_mazePend | bus.start_maze;
  assign w_acceptPlayer = bus.player_req & ~r_playerAck;
  assign w_enterMaze    = (r_state == ST_IDLE) && (w_nextState == ST_MAZE);
  assign w_enterPlayer  = (r_state == ST_IDLE) && (w_nextState == ST_PLAYER);

  tile_box_scanner #(
    .XOFF (XOFF),
    .PITCH(PITCH),
    .BOX  (BOX),
    .GRID (GRID)
  ) u_scanner (
    .clk   (clk),
    .resetn(resetn),
    .start (w_enterPlayer),
    .px    (r_px),
    .py    (r_py),
    .x     (w_scanX),
    .y     (w_scanY),
    .valid (w_scanValid),
    .last  (w_scanLast)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_mazeWant) begin
          w_nextState = ST_MAZE;
        end else if (w_acceptPlayer) begin
          w_nextState = ST_PLAYER;
        end
      end
      ST_MAZE: begin
        if (bus.maze_done) begin
          w_nextState = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_nextState = ST_IDLE;
      end
      ST_PLAYER: begin
        if (!w_scanValid || w_scanLast) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mazePend  <= 1'b0;
      r_playerAck <= 1'b0;
      r_frameDone <= 1'b0;
      r_px        <= '0;
      r_py        <= '0;
      r_colour    <= '0;
    end else begin
      if (w_enterMaze) begin
        r_mazePend <= 1'b0;
      end else if (bus.start_maze) begin
        r_mazePend <= 1'b1;
      end
      if (w_enterPlayer) begin
        r_px     <= bus.player_x;
        r_py     <= bus.player_y;
        r_colour <= bus.player_colour;
      end
      r_playerAck <= (r_state == ST_PLAYER) && (w_nextState == ST_IDLE);
      r_frameDone <= (r_state == ST_FLUSH);
    end
  end

  // Outside MAZE the port shows the scanner pixel, which idles at the tile origin.
  always_comb begin
    bus.plot        = 1'b0;
    bus.maze_enable = 1'b0;
    bus.vga_x       = w_scanX;
    bus.vga_y       = w_scanY;
    bus.vga_colour  = r_colour;
    bus.busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_MAZE: begin
        bus.maze_enable = 1'b1;
        bus.plot        = ~bus.maze_done;
        bus.vga_x       = bus.maze_x;
        bus.vga_y       = bus.maze_y;
        bus.vga_colour  = bus.maze_colour;
      end
      ST_PLAYER: begin
        bus.plot = w_scanValid;
      end
      default: begin
        bus.plot = 1'b0;
      end
    endcase
  end

  assign bus.player_ack = r_playerAck;
  assign bus.frame_done = r_frameDone;

endmodule
